// File: rtl/regfile_arbiter.sv
// Shares the single register-file port between a two-operand fetch sequencer and
// a writeback requester, with bounded write starvation and r0 held at zero.
module regfile_arbiter #(
  parameter int DW         = 33,
  parameter int SW         = 6,
  parameter int MAX_WSTALL = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [SW-1:0] op_rs_a,
  input  logic [SW-1:0] op_rs_b,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_a,
  output logic [DW-1:0] res_b,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [SW-1:0] wr_sel,
  input  logic [DW-1:0] wr_data,
  output logic [SW-1:0] rf_rsel,
  output logic [SW-1:0] rf_wsel,
  output logic [DW-1:0] rf_wdata,
  output logic          rf_wen,
  input  logic [DW-1:0] rf_rdata
);

  typedef enum logic [2:0] {IDLE, ISSUE_A, ISSUE_B, LAST, RESP} state_t;

  state_t        state;
  logic [SW-1:0] rs_a_q;
  logic [SW-1:0] rs_b_q;
  logic [1:0]    wstall;
  logic          a_pend;
  logic          issuing;
  logic          force_read;
  logic          wgrant;
  logic          rd_issue;

  // Select 0 and anything at or above 32 behave as a hard-wired zero register.
  function automatic logic sel_invalid(input logic [SW-1:0] s);
    return (s == '0) || s[5];
  endfunction

  assign issuing    = (state == ISSUE_A) || (state == ISSUE_B);
  assign force_read = issuing && (wstall == 2'(MAX_WSTALL));
  assign wr_ready   = ~rst & ~force_read;
  assign wgrant     = wr_valid & wr_ready;
  assign rd_issue   = issuing & ~wgrant;
  assign op_ready   = ~rst & (state == IDLE);

  assign rf_wen   = wgrant & ~sel_invalid(wr_sel);
  assign rf_wsel  = wgrant ? wr_sel : '0;
  assign rf_wdata = wgrant ? wr_data : '0;
  assign rf_rsel  = (state == ISSUE_A) ? rs_a_q :
                    (state == ISSUE_B) ? rs_b_q : '0;

  // Operand selects are plain data and need no reset.
  always_ff @(posedge clk) begin
    if (op_valid && op_ready) begin
      rs_a_q <= op_rs_a;
      rs_b_q <= op_rs_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      res_valid <= 1'b0;
      res_a     <= '0;
      res_b     <= '0;
      wstall    <= 2'd0;
      a_pend    <= 1'b0;
    end else begin
      a_pend <= (state == ISSUE_A) && rd_issue;
      wstall <= (issuing && wgrant) ? wstall + 2'd1 : 2'd0;
      case (state)
        IDLE:    if (op_valid) state <= ISSUE_A;
        ISSUE_A: if (rd_issue) state <= ISSUE_B;
        ISSUE_B: begin
          // rf_rdata holds the A read only in the cycle right after it issued.
          if (a_pend) res_a <= sel_invalid(rs_a_q) ? '0 : rf_rdata;
          if (rd_issue) state <= LAST;
        end
        LAST: begin
          res_b     <= sel_invalid(rs_b_q) ? '0 : rf_rdata;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Sequencer and arbiter for the CPU register file: the file has one combined select/data port that either writes (wen high) or performs a registered read (wen low) on each rising clock edge. This block shares that port between an operand-fetch requester, which needs two source registers per operation, and a writeback requester. It sequences the two reads, arbitrates writes against them with a bounded-starvation rule, and enforces register 0 as constant zero. It sits between decode/writeback and register_file.

## Interface
- DW, 33, data width; matches register file data.
- SW, 6, register select width; selects 0-31 are valid.
- MAX_WSTALL, 3, max consecutive write grants allowed while a read is pending.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- op_valid  in  1  operand-fetch request.
- op_ready  out  1  high only in IDLE.
- op_rs_a, op_rs_b  in  SW  source selects.
- res_valid  out  1  operands available.
- res_ready  in  1  consumer accepts operands.
- res_a, res_b  out  DW  operand values.
- wr_valid  in  1  writeback request.
- wr_ready  out  1  write accepted this cycle.
- wr_sel  in  SW  destination select.
- wr_data  in  DW  write data.
- rf_rsel, rf_wsel  out  SW  to register file.
- rf_wdata  out  DW  to register file.
- rf_wen  out  1  to register file.
- rf_rdata  in  DW  from register file; valid one cycle after a read issue.

## Operation
- Port use is exclusive per cycle. A write grant takes the port. A read issues only in a cycle with rf_wen=0.
- FSM states: IDLE, ISSUE_A, ISSUE_B, LAST, RESP.
  - IDLE: op_valid and op_ready capture rs_a and rs_b, then go to ISSUE_A.
  - ISSUE_A: rf_rsel=rs_a. If no write is granted, the read issues and the FSM goes to ISSUE_B; otherwise it stays.
  - ISSUE_B: rf_rsel=rs_b. In the first cycle of the state, rf_rdata is captured into res_a, using a one-shot flag set by the A issue. If no write is granted, the read issues and the FSM goes to LAST; otherwise it stays.
  - LAST: rf_rdata is captured into res_b, then go to RESP. The port is free for writes in this state.
  - RESP: res_valid=1. res_a and res_b are held stable until res_ready, then go to IDLE.
- rf_rsel is 0 in IDLE, LAST and RESP.
- Write path (combinational pass-through):
  - wr_ready = ~rst & ~force_read.
  - On wr_valid & wr_ready: rf_wen=1, rf_wsel=wr_sel, rf_wdata=wr_data.
  - A write to select 0, or to any select with bit 5 set, completes the handshake but rf_wen stays 0 (dropped).
- Zero/invalid reads: if a captured select is 0 or has bit 5 set, the captured operand is forced to 0. The read cycle is still consumed.
- Starvation counter wstall (2 bits):
  - Increments on each write grant while in ISSUE_A or ISSUE_B.
  - Clears on a read issue or in any other state.
  - When wstall == MAX_WSTALL, force_read=1: wr_ready=0, and the read issues that cycle.
- Coherency: each operand reflects register contents at the edge of its own read issue. There is no bypass; a write granted in the same cycle as the op handshake is visible to both reads.

## Timing
- Reset (async): state=IDLE, res_valid=0, res_a=res_b=0, wstall=0, flag=0, rf_wen=0, wr_ready=0, rf_rsel=rf_wsel=0, rf_wdata=0. op_ready=1 after rst deasserts.
- Uncontended latency: handshake at cycle 0, ISSUE_A at cycle 1, ISSUE_B at cycle 2, LAST at cycle 3, res_valid at cycle 4.
- Throughput is at most one op per 5 cycles; op_ready is low from ISSUE_A through RESP.
- Each read is delayed by at most MAX_WSTALL cycles, so worst-case res_valid is at cycle 4+2*MAX_WSTALL.
- Writes complete with zero latency when wr_ready is high. Write throughput is one per cycle outside force_read cycles.
- Reset asserted mid-operation aborts the op with no response. A write in flight during reset is not performed.
- res_valid & res_ready in the same cycle returns to IDLE the next cycle. A new op can be accepted no earlier than that cycle.

## Test plan
- Reset then op rs_a=5 and rs_b=6, after preloading r5=0x1_0000_0005 and r6=0x0_DEAD_BEEF -> res_valid at cycle 4 with res_a=0x1_0000_0005 and res_b=0x0_DEAD_BEEF; op_ready back at cycle 5.
- Continuous wr_valid to r9 during an op -> wr_ready drops exactly every 4th cycle in the issue states; res_valid at cycle 10.
- Write r0=0x1_FFFF_FFFF, then op rs_a=0 and rs_b=32 -> rf_wen never high; res_a=0 and res_b=0.
- Write r3=7 in the same cycle as the op handshake (rs_a=3), then write r3=9 during ISSUE_B -> res_a=7; a subsequent op reads 9.
- Hold res_ready low for 6 cycles in RESP -> res_a and res_b stable, op_ready=0, writes still accepted every cycle.
- Assert rst in ISSUE_B -> res_valid never rises; op_ready=1 the cycle after release; all outputs at reset values.
